// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : arbiter FSM state encoding
//   DefN        : default number of requesters
//   DefTimeout  : default watchdog limit (cycles spent waiting for busy_tx)
//   CntW        : watchdog counter width
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } arb_state_e;

  localparam int unsigned DefN       = 4;
  localparam int unsigned DefTimeout = 16;
  localparam int unsigned CntW       = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters / UART and the transmit arbiter.
//   req[N]        requester byte request (level)
//   data[8*N]     requester i byte on data[8*i+7:8*i]
//   ack[N]        one-cycle pulse, requester's byte taken
//   transmit      one-cycle launch pulse to the UART
//   data_tx[8]    byte handed to the UART
//   busy_tx       UART frame in flight
//   active        arbiter not idle
//   active_id     current / last granted requester
//   err           one-cycle pulse on watchdog abort
// master: requesters + UART side; slave: arbiter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned N   = uart_pkg::DefN,
  parameter int unsigned IDW = 2
) ();

  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic           transmit;
  logic [7:0]     data_tx;
  logic           busy_tx;
  logic           active;
  logic [IDW-1:0] active_id;
  logic           err;

  modport master (
    output req, data, busy_tx,
    input  ack, transmit, data_tx, active, active_id, err
  );

  modport slave (
    input  req, data, busy_tx,
    output ack, transmit, data_tx, active, active_id, err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req[N]    request vector
//   ptr[IDW]  last granted index; search starts at ptr+1 and wraps mod N
//   valid     at least one request present
//   idx[IDW]  winning requester (ptr when nothing is requested)
module uart_rr_pick #(
  parameter int unsigned N   = uart_pkg::DefN,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] w_cand;

  // The pointer itself is checked last (offset N), so a lone requester that
  // was just served can still win again.
  always_comb begin
    valid  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_cand = IDW'((ptr + off) % N);
      if (!valid && req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
// One byte is launched per grant; the arbiter waits for the UART frame to
// complete before re-arbitrating. A watchdog aborts a launch the UART never
// acknowledges with busy_tx.
//   clk   system clock
//   nRst  asynchronous active-low reset
//   bus   uart_tx_arbiter_if.slave (requests, UART handshake, status)
// All outputs are registered.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic               clk,
  input  logic               nRst,
  uart_tx_arbiter_if.slave   bus
);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  IdReset     = IDW'(N - 1);

  arb_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [N-1:0]    r_ack, w_ack_d;
  logic            r_transmit, w_transmit_d;
  logic [7:0]      r_data_tx, w_data_tx_d;
  logic            r_active, w_active_d;
  logic [IDW-1:0]  r_active_id, w_active_id_d;
  logic            r_err, w_err_d;

  logic            w_pick_valid;
  logic [IDW-1:0]  w_pick_idx;
  logic [7:0]      w_pick_byte;

  // active_id doubles as the round-robin pointer; its reset value of N-1
  // gives requester 0 top priority after reset.
  uart_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (r_active_id),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_idx == IDW'(i)) begin
        w_pick_byte = bus.data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_ack_d       = '0;
    w_transmit_d  = 1'b0;
    w_data_tx_d   = r_data_tx;
    w_active_d    = r_active;
    w_active_id_d = r_active_id;
    w_err_d       = 1'b0;

    unique case (r_state)
      StIdle: begin
        // A UART still busy from elsewhere blocks new grants.
        if (w_pick_valid && !bus.busy_tx) begin
          w_active_id_d       = w_pick_idx;
          w_data_tx_d         = w_pick_byte;
          w_ack_d[w_pick_idx] = 1'b1;
          w_active_d          = 1'b1;
          w_state_d           = StLaunch;
        end
      end
      StLaunch: begin
        w_transmit_d = 1'b1;
        w_cnt_d      = '0;
        w_state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.busy_tx) begin
          w_state_d = StWaitDone;
        end else if (r_cnt == TimeoutLast) begin
          // Byte is dropped; the requester already had its ack.
          w_err_d    = 1'b1;
          w_active_d = 1'b0;
          w_state_d  = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.busy_tx) begin
          w_active_d = 1'b0;
          w_state_d  = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_transmit  <= 1'b0;
      r_data_tx   <= 8'h00;
      r_active    <= 1'b0;
      r_active_id <= IdReset;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_ack       <= w_ack_d;
      r_transmit  <= w_transmit_d;
      r_data_tx   <= w_data_tx_d;
      r_active    <= w_active_d;
      r_active_id <= w_active_id_d;
      r_err       <= w_err_d;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.transmit  = r_transmit;
  assign bus.data_tx   = r_data_tx;
  assign bus.active    = r_active;
  assign bus.active_id = r_active_id;
  assign bus.err       = r_err;

endmodule
